// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB initiator slice.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned APB_TIMEOUT_CYCLES = 255;
    localparam int unsigned APB_TO_W           = $clog2(APB_TIMEOUT_CYCLES + 1);

    // Counter width needed to hold values 0..cycles.
    function automatic int unsigned apb_to_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-state counter; expire_o flags the wait cycle that reaches the limit.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = APB_TO_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The incrementing cycle that would bring the count to TIMEOUT_CYCLES expires.
    assign expire_o = inc_i & (cnt_q == LAST);

endmodule

// File: rtl/apb_initiator.sv
// Single-outstanding APB3/APB4 initiator: req/gnt/rvalid core port to APB SETUP/ACCESS.
// Optional ACCESS wait-state timeout enabled by defining APB_INITIATOR_TIMEOUT_EN.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_i,
    input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic                        we_i,
    input  logic [APB_DATA_WIDTH/8-1:0] be_i,
    input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output logic                        psel_o,
    output logic                        penable_o,
    output logic                        pwrite_o,
    output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
    output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
    output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
    input  logic                        pready_i,
    input  logic                        pslverr_i
);

    localparam int unsigned SW = APB_DATA_WIDTH / 8;

    apb_state_e                state_q,  state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q,  paddr_d;
    logic                      pwrite_q, pwrite_d;
    logic [SW-1:0]             pstrb_q,  pstrb_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      rvalid_q, rvalid_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic                      err_q,    err_d;
    logic                      gnt;
    logic                      expire;

`ifdef APB_INITIATOR_TIMEOUT_EN
    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (apb_to_width(TIMEOUT_CYCLES))
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == APB_SETUP),
        .inc_i    ((state_q == APB_ACCESS) && !pready_i),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Grant, next state, request capture and completion capture.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pstrb_d  = pstrb_q;
        pwdata_d = pwdata_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;

        // A timeout completion is not pready, so it never grants.
        gnt = req_i & ((state_q == APB_IDLE) | ((state_q == APB_ACCESS) & pready_i));

        case (state_q)
            APB_IDLE: begin
                if (gnt) state_d = APB_SETUP;
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (pready_i) begin
                    rvalid_d = 1'b1;
                    err_d    = pslverr_i;
                    rdata_d  = pwrite_q ? '0 : prdata_i;
                    state_d  = gnt ? APB_SETUP : APB_IDLE;
                end else if (expire) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    state_d  = APB_IDLE;
                end
            end
            default: begin
                state_d = APB_IDLE;
            end
        endcase

        if (gnt) begin
            paddr_d  = addr_i;
            pwrite_d = we_i;
            pstrb_d  = we_i ? be_i : '0;
            pwdata_d = wdata_i;
        end
    end

    // State, APB request and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= APB_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pstrb_q  <= '0;
            pwdata_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pstrb_q  <= pstrb_d;
            pwdata_q <= pwdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign gnt_o     = gnt;
    assign psel_o    = (state_q != APB_IDLE);
    assign penable_o = (state_q == APB_ACCESS);
    assign pwrite_o  = pwrite_q;
    assign pstrb_o   = pstrb_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;

endmodule
